// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared defaults, port indices and write-request record
// for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic [AW_DEF-1:0] regsel;
    logic [DW_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// rtl/rf_wb_arbiter_wb_fifo.sv - per-requester circular write queue
// with head view and flattened entry-valid/regsel view for hazard tracking.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AW-1:0]       push_regsel,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [AW-1:0]       head_regsel,
  output logic [DW-1:0]       head_data,
  output logic [DEPTH-1:0]    ent_valid,
  output logic [DEPTH*AW-1:0] ent_regsel
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] regsel_q [DEPTH];
  logic [AW-1:0] regsel_d [DEPTH];
  logic [DW-1:0] data_q   [DEPTH];
  logic [DW-1:0] data_d   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full        = (count_q == (PW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign head_regsel = regsel_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];

  always_comb begin
    regsel_d = regsel_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      regsel_d[wr_ptr_q] = push_regsel;
      data_d[wr_ptr_q]   = push_data;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer (mod DEPTH) is below the count.
  always_comb begin
    ent_valid  = '0;
    ent_regsel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i]             = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      ent_regsel[i*AW +: AW]   = regsel_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    regsel_q <= regsel_d;
    data_q   <= data_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin sharing of the rf write port between the
// ALU (A) and load-return (B) writeback queues, with per-register busy vector.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_regsel,
  input  logic [DW-1:0]    a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_regsel,
  input  logic [DW-1:0]    b_data,
  output logic             rf_write,
  output logic [AW-1:0]    rf_writeregsel,
  output logic [DW-1:0]    rf_writedata,
  output logic [2**AW-1:0] busy,
  output logic             err
);

  logic             a_full, a_empty, b_full, b_empty;
  logic [AW-1:0]    a_head_regsel, b_head_regsel;
  logic [DW-1:0]    a_head_data, b_head_data;
  logic [DEPTH-1:0] a_ent_valid, b_ent_valid;
  logic [DEPTH*AW-1:0] a_ent_regsel, b_ent_regsel;
  logic             grant_a, grant_b;

  logic             last_q, last_d;
  logic             rf_write_q, rf_write_d;
  logic [AW-1:0]    rf_writeregsel_q, rf_writeregsel_d;
  logic [DW-1:0]    rf_writedata_q, rf_writedata_d;
  logic             err_q, err_d;
  logic [AW-1:0]    a_prev_regsel_q, a_prev_regsel_d, b_prev_regsel_q, b_prev_regsel_d;
  logic [DW-1:0]    a_prev_data_q, a_prev_data_d, b_prev_data_q, b_prev_data_d;

  assign a_ready = !a_full;
  assign b_ready = !b_full;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk         (clk),
    .rst         (rst),
    .push        (a_valid && a_ready),
    .push_regsel (a_regsel),
    .push_data   (a_data),
    .pop         (grant_a),
    .full        (a_full),
    .empty       (a_empty),
    .head_regsel (a_head_regsel),
    .head_data   (a_head_data),
    .ent_valid   (a_ent_valid),
    .ent_regsel  (a_ent_regsel)
  );

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk         (clk),
    .rst         (rst),
    .push        (b_valid && b_ready),
    .push_regsel (b_regsel),
    .push_data   (b_data),
    .pop         (grant_b),
    .full        (b_full),
    .empty       (b_empty),
    .head_regsel (b_head_regsel),
    .head_data   (b_head_data),
    .ent_valid   (b_ent_valid),
    .ent_regsel  (b_ent_regsel)
  );

  // Same-register heads always go A first so the older producer's write lands first.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    last_d  = last_q;
    if (!a_empty && !b_empty) begin
      if (a_head_regsel == b_head_regsel) begin
        grant_a = 1'b1;
      end else if (last_q == PORT_B) begin
        grant_a = 1'b1;
        last_d  = PORT_A;
      end else begin
        grant_b = 1'b1;
        last_d  = PORT_B;
      end
    end else if (!a_empty) begin
      grant_a = 1'b1;
    end else if (!b_empty) begin
      grant_b = 1'b1;
    end
  end

  always_comb begin
    rf_write_d       = grant_a || grant_b;
    rf_writeregsel_d = rf_writeregsel_q;
    rf_writedata_d   = rf_writedata_q;
    if (grant_a) begin
      rf_writeregsel_d = a_head_regsel;
      rf_writedata_d   = a_head_data;
    end else if (grant_b) begin
      rf_writeregsel_d = b_head_regsel;
      rf_writedata_d   = b_head_data;
    end
  end

  // A stalled requester must hold its request; any change while blocked is flagged.
  always_comb begin
    err_d           = err_q;
    a_prev_regsel_d = a_regsel;
    a_prev_data_d   = a_data;
    b_prev_regsel_d = b_regsel;
    b_prev_data_d   = b_data;
    if (a_valid && !a_ready && (a_regsel != a_prev_regsel_q || a_data != a_prev_data_q)) begin
      err_d = 1'b1;
    end
    if (b_valid && !b_ready && (b_regsel != b_prev_regsel_q || b_data != b_prev_data_q)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_valid[i]) busy[a_ent_regsel[i*AW +: AW]] = 1'b1;
      if (b_ent_valid[i]) busy[b_ent_regsel[i*AW +: AW]] = 1'b1;
    end
    if (rf_write_q) busy[rf_writeregsel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q           <= PORT_B;
      rf_write_q       <= 1'b0;
      rf_writeregsel_q <= '0;
      rf_writedata_q   <= '0;
      err_q            <= 1'b0;
      a_prev_regsel_q  <= '0;
      a_prev_data_q    <= '0;
      b_prev_regsel_q  <= '0;
      b_prev_data_q    <= '0;
    end else begin
      last_q           <= last_d;
      rf_write_q       <= rf_write_d;
      rf_writeregsel_q <= rf_writeregsel_d;
      rf_writedata_q   <= rf_writedata_d;
      err_q            <= err_d;
      a_prev_regsel_q  <= a_prev_regsel_d;
      a_prev_data_q    <= a_prev_data_d;
      b_prev_regsel_q  <= b_prev_regsel_d;
      b_prev_data_q    <= b_prev_data_d;
    end
  end

  assign rf_write       = rf_write_q;
  assign rf_writeregsel = rf_writeregsel_q;
  assign rf_writedata   = rf_writedata_q;
  assign err            = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter: vector table,
// hand sequences for corner cases and randomized traffic against a queue model.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_regsel, b_regsel;
  logic [DW-1:0] a_data, b_data;
  logic          rf_write;
  logic [AW-1:0] rf_writeregsel;
  logic [DW-1:0] rf_writedata;
  logic [7:0]    busy;
  logic          err;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_regsel       (a_regsel),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_regsel       (b_regsel),
    .b_data         (b_data),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: two plain queues, a "whose turn" bit and the staged output.
  wr_req_t    mq_a[$];
  wr_req_t    mq_b[$];
  logic       m_last = 1'b1;
  logic       m_wr = 1'b0;
  logic [2:0] m_reg = '0;
  logic [15:0] m_data = '0;
  logic       m_err = 1'b0;
  logic [2:0] pa_reg = '0, pb_reg = '0;
  logic [15:0] pa_data = '0, pb_data = '0;
  logic [15:0] rf_img [8];
  int         rf_a_cnt = 0;
  int         hs_a = 0;

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    b = '0;
    foreach (mq_a[i]) b[mq_a[i].regsel] = 1'b1;
    foreach (mq_b[i]) b[mq_b[i].regsel] = 1'b1;
    if (m_wr) b[m_reg] = 1'b1;
    return b;
  endfunction

  task automatic model_edge();
    wr_req_t h;
    bit ra, rb, pop_a, pop_b;
    if (!rst) begin
      mq_a.delete(); mq_b.delete();
      m_last = 1'b1; m_wr = 1'b0; m_reg = '0; m_data = '0; m_err = 1'b0;
      pa_reg = '0; pa_data = '0; pb_reg = '0; pb_data = '0;
      return;
    end
    ra = mq_a.size() < DEPTH;
    rb = mq_b.size() < DEPTH;
    if (a_valid && ra) hs_a++;
    if (a_valid && !ra && (a_regsel != pa_reg || a_data != pa_data)) m_err = 1'b1;
    if (b_valid && !rb && (b_regsel != pb_reg || b_data != pb_data)) m_err = 1'b1;
    pop_a = 0; pop_b = 0;
    if (mq_a.size() > 0 && mq_b.size() > 0) begin
      if (mq_a[0].regsel == mq_b[0].regsel) pop_a = 1;
      else if (m_last) begin pop_a = 1; m_last = 1'b0; end
      else begin pop_b = 1; m_last = 1'b1; end
    end else if (mq_a.size() > 0) pop_a = 1;
    else if (mq_b.size() > 0) pop_b = 1;
    m_wr = pop_a || pop_b;
    if (pop_a) begin h = mq_a.pop_front(); m_reg = h.regsel; m_data = h.data; end
    else if (pop_b) begin h = mq_b.pop_front(); m_reg = h.regsel; m_data = h.data; end
    if (a_valid && ra) begin h.regsel = a_regsel; h.data = a_data; mq_a.push_back(h); end
    if (b_valid && rb) begin h.regsel = b_regsel; h.data = b_data; mq_b.push_back(h); end
    pa_reg = a_regsel; pa_data = a_data; pb_reg = b_regsel; pb_data = b_data;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (rf_write === 1'b1) begin
      rf_img[rf_writeregsel] = rf_writedata;
      if (rf_writedata[15:12] == 4'hA) rf_a_cnt++;
    end
    chk("m_rf_write", rf_write, m_wr);
    chk("m_regsel", rf_writeregsel, m_reg);
    chk("m_data", rf_writedata, m_data);
    chk("m_a_ready", a_ready, mq_a.size() < DEPTH);
    chk("m_b_ready", b_ready, mq_b.size() < DEPTH);
    chk("m_busy", busy, m_busy());
    chk("m_err", err, m_err);
  endtask

  task automatic fill_a(output bit seen);
    seen = 0;
    a_valid = 1; a_regsel = 3'd7; a_data = 16'hA2A2;
    b_valid = 1; b_regsel = 3'd0; b_data = 16'hB0B0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (!a_ready) seen = 1;
    end
  endtask

  typedef struct {
    logic av; logic [2:0] ar; logic [15:0] ad;
    logic bv; logic [2:0] br; logic [15:0] bd;
    logic ew; logic [2:0] er; logic [15:0] ed;
    logic ea; logic eb; logic [7:0] ebusy;
  } vec_t;
  vec_t tbl [8];

  initial begin
    bit seen;
    tbl[0] = '{1'b1, 3'd1, 16'hA001, 1'b1, 3'd4, 16'hB004, 1'b0, 3'd3, 16'h1234, 1'b1, 1'b1, 8'h12};
    tbl[1] = '{1'b1, 3'd2, 16'hA002, 1'b1, 3'd5, 16'hB005, 1'b1, 3'd1, 16'hA001, 1'b1, 1'b0, 8'h36};
    tbl[2] = '{1'b1, 3'd3, 16'hA003, 1'b0, 3'd6, 16'hB006, 1'b1, 3'd4, 16'hB004, 1'b0, 1'b1, 8'h3C};
    tbl[3] = '{1'b0, 3'd3, 16'hA003, 1'b1, 3'd6, 16'hB006, 1'b1, 3'd2, 16'hA002, 1'b1, 1'b0, 8'h6C};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hB005, 1'b1, 1'b1, 8'h68};
    tbl[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hA003, 1'b1, 1'b1, 8'h48};
    tbl[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'hB006, 1'b1, 1'b1, 8'h40};
    tbl[7] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 16'hB006, 1'b1, 1'b1, 8'h00};

    // Reset with both requesters asserting
    rst = 0; a_valid = 1; b_valid = 1;
    a_regsel = 3'd7; a_data = 16'h5555; b_regsel = 3'd6; b_data = 16'h6666;
    repeat (2) step();
    rst = 1; a_valid = 0; b_valid = 0;
    chk("rst_rf_write", rf_write, 0);
    chk("rst_regsel", rf_writeregsel, 0);
    chk("rst_data", rf_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_err", err, 0);

    // Single write latency
    a_valid = 1; a_regsel = 3'd3; a_data = 16'h1234;
    step();
    a_valid = 0;
    chk("single_busy_k", busy[3], 1);
    chk("single_wr_k", rf_write, 0);
    step();
    chk("single_wr_k1", rf_write, 1);
    chk("single_reg_k1", rf_writeregsel, 3);
    chk("single_data_k1", rf_writedata, 16'h1234);
    chk("single_busy_k1", busy[3], 1);
    step();
    chk("single_wr_k2", rf_write, 0);
    chk("single_busy_k2", busy[3], 0);

    // Contention with distinct registers
    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].av; a_regsel = tbl[i].ar; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_regsel = tbl[i].br; b_data = tbl[i].bd;
      step();
      chk($sformatf("tbl%0d_wr", i), rf_write, tbl[i].ew);
      chk($sformatf("tbl%0d_reg", i), rf_writeregsel, tbl[i].er);
      chk($sformatf("tbl%0d_data", i), rf_writedata, tbl[i].ed);
      chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ea);
      chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].eb);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
    end

    // Same-register collision while the turn favours B
    a_valid = 1; a_regsel = 3'd2; a_data = 16'hAAAA;
    b_valid = 1; b_regsel = 3'd2; b_data = 16'hBBBB;
    step();
    a_valid = 0; b_valid = 0;
    step();
    chk("coll_first_reg", rf_writeregsel, 2);
    chk("coll_first_data", rf_writedata, 16'hAAAA);
    step();
    chk("coll_second_data", rf_writedata, 16'hBBBB);
    step();
    chk("coll_final_r2", rf_img[2], 16'hBBBB);

    // Collision must not have moved the turn: B still wins the next distinct contention
    a_valid = 1; a_regsel = 3'd1; a_data = 16'hA011;
    b_valid = 1; b_regsel = 3'd4; b_data = 16'hB044;
    step();
    a_valid = 0; b_valid = 0;
    step();
    chk("turn_b_first", rf_writedata, 16'hB044);
    step();
    chk("turn_a_second", rf_writedata, 16'hA011);
    repeat (2) step();

    // Backpressure: A alone streams at full rate, then contention fills A
    rf_a_cnt = 0; hs_a = 0;
    a_valid = 1; b_valid = 0;
    for (int i = 0; i < 6; i++) begin
      a_regsel = 3'(i); a_data = 16'hA100 + 16'(i);
      step();
      chk($sformatf("bp_ready_%0d", i), a_ready, 1);
    end
    fill_a(seen);
    chk("bp_full_seen", seen, 1);
    step();
    chk("bp_err_hold", err, 0);
    a_valid = 0; b_valid = 0;
    repeat (8) step();
    chk("bp_a_count", rf_a_cnt, hs_a);

    // Mid-operation reset discards queued writes
    a_valid = 1; a_regsel = 3'd5; a_data = 16'hA055;
    b_valid = 1; b_regsel = 3'd6; b_data = 16'hB066;
    step();
    a_valid = 0; b_valid = 0;
    chk("mrst_busy_pre", busy, 8'h60);
    rst = 0;
    step();
    rst = 1;
    chk("mrst_wr", rf_write, 0);
    chk("mrst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_wr_after_%0d", i), rf_write, 0);
    end

    // Dropping a stalled request sets a sticky error
    fill_a(seen);
    chk("err_full_seen", seen, 1);
    chk("err_before", err, 0);
    a_data = 16'h5A5A;
    step();
    chk("err_set", err, 1);
    a_valid = 0; b_valid = 0;
    repeat (5) step();
    chk("err_sticky", err, 1);
    rst = 0;
    step();
    rst = 1;
    chk("err_cleared", err, 0);

    // Randomized traffic; stalled requests are mostly held, occasionally dropped
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!(a_valid && !a_ready && $urandom_range(0, 9) != 0)) begin
        a_valid = 1'($urandom_range(0, 1));
        a_regsel = 3'($urandom_range(0, 7));
        a_data = 16'($urandom);
      end
      if (!(b_valid && !b_ready && $urandom_range(0, 9) != 0)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_regsel = 3'($urandom_range(0, 7));
        b_data = 16'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (memory load return).
- Each requester has its own small FIFO, and a round-robin arbiter pops at most one write per cycle into a registered write-port output.
- The block exports a per-register pending-write vector so decode can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the rf write inputs (writeregsel, writedata, write).

Parameters:
- DW, 16, data width of a write (matches rf writedata).
- AW, 3, register-select width (8 registers).
- DEPTH, 2, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-low reset: rst==0 at a rising edge resets the block.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A can accept; equals !a_full.
- a_regsel  in  AW  port A destination register.
- a_data  in  DW  port A write data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B can accept; equals !b_full.
- b_regsel  in  AW  port B destination register.
- b_data  in  DW  port B write data.
- rf_write  out  1  to rf write.
- rf_writeregsel  out  AW  to rf writeregsel.
- rf_writedata  out  DW  to rf writedata.
- busy  out  2**AW  bit r=1 while any queued or output-staged write targets register r.
- err  out  1  sticky protocol error (see Behaviour).

Behaviour:
- Reset (rst==0 at edge):
  - both FIFOs empty; rf_write=0, rf_writeregsel=0, rf_writedata=0.
  - last-grant pointer = B, so A wins the first contention.
  - err=0; busy=0 in the following cycle.
  - Reset mid-operation discards all queued writes; none reach the rf.
- Accept: a transfer occurs at an edge where valid&&ready. ready depends only on the FIFO being full, never on a same-cycle pop, so a full FIFO does not accept even while popping.
- FIFO: circular buffer with read/write pointers and a count of 0..DEPTH; pointers wrap modulo DEPTH.
- Arbitration (combinational on FIFO heads, acts at the edge):
  - only one FIFO non-empty: pop it.
  - both non-empty, different regsel: grant the port not granted last; update the pointer.
  - both non-empty, same regsel: grant A regardless of the pointer; pointer unchanged. A is the older producer by pipeline position.
  - both empty: no pop.
- Output register: at each edge, rf_write <= (pop occurred); on a pop, rf_writeregsel/rf_writedata <= popped head. With no pop, rf_write=0 and regsel/data hold their previous values.
- Latency: a write accepted at edge k pops no earlier than edge k+1, drives rf_write=1 during the cycle after k+1, and is written into the rf at edge k+2. There is no bypass from input to output.
- Throughput: 1 write/cycle in total. Under sustained contention with distinct registers, A and B alternate.
- busy[r]: OR over all valid FIFO entries of both ports and the output register (when rf_write=1) whose regsel==r. Purely combinational from state.
- err: set at an edge where valid==1 and ready==0 and the request's regsel/data differ from the previous cycle's values on that port (requester dropped a stalled request). Cleared only by reset.

Decomposition:
- Shared package: DW/AW defaults, the port-index constants PORT_A=0 and PORT_B=1, and the write-request record (regsel, data).
- Sub-module wb_fifo (parameterised DEPTH/AW/DW; push/pop/full/empty/head, plus a flattened entry-valid/regsel view for busy), instantiated twice.
- The arbiter, output register and busy logic live in the top level.

Test Plan:
- Reset: drive rst=0 for 2 cycles with a_valid=b_valid=1. Required: rf_write=0, busy=0, a_ready=b_ready=1, err=0 after release.
- Single write: A sends reg 3 data 0x1234 at edge k. Required: busy[3]=1 after k; rf_write=1, regsel=3, data=0x1234 in the cycle after k+1; busy[3]=0 after k+2.
- Contention, distinct regs: A and B each send 3 writes (A: r1..r3, B: r4..r6) on the same cycles. Required: rf order A1,B4,A2,B5,A3,B6, with rf_write high for 6 consecutive cycles.
- Same-reg collision: heads A→r2=0xAAAA and B→r2=0xBBBB with the pointer favouring B. Required: A written first, then B; final rf r2=0xBBBB.
- Backpressure: hold B empty, push A every cycle. Required: a_ready never deasserts (1 pop/cycle). Then stall the output by making A and B contend, fill A to DEPTH: a_ready=0 while full, and no extra entry is accepted.
- Mid-operation reset plus err: queue 2 writes, assert rst=0 for 1 cycle. Required: neither write appears on rf_write, busy=0. Separately, change a_data while a_ready=0 and a_valid=1. Required: err=1, staying set until reset.
